// File: rtl/obstacle_spawner.sv
// rtl/obstacle_spawner.sv - four-slot falling obstacle pool with periodic spawning
module obstacle_spawner #(
    parameter int SPAWN_INTERVAL = 60,
    parameter int FALL_STEP      = 2,
    parameter int VBP            = 31,
    parameter int VLIMIT         = 511
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic        start,
    input  logic        pause,
    input  logic [9:0]  rand_hpos,
    input  logic [3:0]  clear_slot,
    output logic [3:0]  obj_valid,
    output logic [39:0] obj_hpos,
    output logic [39:0] obj_vpos,
    output logic        spawned,
    output logic        missed,
    output logic        overflow
);

    localparam int CW = (SPAWN_INTERVAL > 1) ? $clog2(SPAWN_INTERVAL) : 1;

    typedef enum logic [1:0] {IDLE, RUN, PAUSED} state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [3:0]      valid_q, valid_d;
    logic [3:0][9:0] hpos_q, hpos_d;
    logic [3:0][9:0] vpos_q, vpos_d;
    logic            spawned_q, spawned_d;
    logic            missed_q, missed_d;
    logic            overflow_q, overflow_d;
    logic [10:0]     sum;
    logic            found;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        valid_d    = valid_q;
        hpos_d     = hpos_q;
        vpos_d     = vpos_q;
        spawned_d  = 1'b0;
        missed_d   = 1'b0;
        overflow_d = 1'b0;
        sum        = '0;
        found      = 1'b0;
        case (state_q)
            IDLE: begin
                valid_d = '0;
                cnt_d   = '0;
                if (start) state_d = RUN;
            end
            RUN: begin
                if (pause) state_d = PAUSED;
                if (frame_tick) begin
                    // Slots being cleared this cycle neither move nor count as misses.
                    for (int i = 0; i < 4; i++) begin
                        if (valid_q[i] && !clear_slot[i]) begin
                            sum = {1'b0, vpos_q[i]} + 11'(FALL_STEP);
                            if (sum >= 11'(VLIMIT)) begin
                                valid_d[i] = 1'b0;
                                missed_d   = 1'b1;
                            end else begin
                                vpos_d[i] = sum[9:0];
                            end
                        end
                    end
                    if (cnt_q == CW'(SPAWN_INTERVAL - 1)) begin
                        cnt_d = '0;
                        // Free-slot search uses pre-update occupancy so freed slots wait a cycle.
                        for (int i = 0; i < 4; i++) begin
                            if (!valid_q[i] && !found) begin
                                found      = 1'b1;
                                valid_d[i] = 1'b1;
                                hpos_d[i]  = rand_hpos;
                                vpos_d[i]  = 10'(VBP);
                            end
                        end
                        spawned_d  = found;
                        overflow_d = !found;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            PAUSED: begin
                if (pause) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
        valid_d = valid_d & ~clear_slot;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            valid_q    <= '0;
            hpos_q     <= '0;
            vpos_q     <= '0;
            spawned_q  <= 1'b0;
            missed_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            valid_q    <= valid_d;
            hpos_q     <= hpos_d;
            vpos_q     <= vpos_d;
            spawned_q  <= spawned_d;
            missed_q   <= missed_d;
            overflow_q <= overflow_d;
        end
    end

    assign obj_valid = valid_q;
    assign obj_hpos  = hpos_q;
    assign obj_vpos  = vpos_q;
    assign spawned   = spawned_q;
    assign missed    = missed_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_obstacle_spawner.sv
// tb/tb_obstacle_spawner.sv - randomized directed bench with a behavioural slot-pool model
module tb_obstacle_spawner;

    localparam int SI = 60;
    localparam int FS = 2;
    localparam int VB = 31;
    localparam int VL = 511;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic [9:0]  rand_hpos = '0;
    logic [3:0]  clear_slot = '0;
    logic [3:0]  obj_valid;
    logic [39:0] obj_hpos;
    logic [39:0] obj_vpos;
    logic        spawned;
    logic        missed;
    logic        overflow;

    always #5 clk = ~clk;

    obstacle_spawner #(
        .SPAWN_INTERVAL(SI), .FALL_STEP(FS), .VBP(VB), .VLIMIT(VL)
    ) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .start(start), .pause(pause),
        .rand_hpos(rand_hpos), .clear_slot(clear_slot), .obj_valid(obj_valid),
        .obj_hpos(obj_hpos), .obj_vpos(obj_vpos), .spawned(spawned), .missed(missed),
        .overflow(overflow)
    );

    int errors = 0;
    int checks = 0;

    // Model: mode 0 idle, 1 running, 2 paused; frames counted since last attempt.
    int m_mode = 0;
    int m_frames = 0;
    bit m_v[4];
    int m_h[4];
    int m_y[4];
    bit m_sp, m_ms, m_ov;

    bit         use_fixed = 1'b0;
    logic [9:0] fixed_h = 10'd415;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int lane();
        case ($urandom_range(0, 2))
            0: return 295;
            1: return 415;
            default: return 535;
        endcase
    endfunction

    task automatic model_step();
        bit nv[4];
        int nh[4];
        int ny[4];
        int slot;
        for (int i = 0; i < 4; i++) begin
            nv[i] = m_v[i];
            nh[i] = m_h[i];
            ny[i] = m_y[i];
        end
        m_sp = 0; m_ms = 0; m_ov = 0;
        if (rst) begin
            m_mode = 0;
            m_frames = 0;
            for (int i = 0; i < 4; i++) begin
                nv[i] = 0; nh[i] = 0; ny[i] = 0;
            end
        end else begin
            if (m_mode == 0) begin
                for (int i = 0; i < 4; i++) nv[i] = 0;
                m_frames = 0;
                if (start) m_mode = 1;
            end else if (m_mode == 1) begin
                if (frame_tick) begin
                    for (int i = 0; i < 4; i++) begin
                        if (m_v[i] && !clear_slot[i]) begin
                            if (m_y[i] + FS >= VL) begin
                                nv[i] = 0;
                                m_ms = 1;
                            end else begin
                                ny[i] = m_y[i] + FS;
                            end
                        end
                    end
                    m_frames++;
                    if (m_frames == SI) begin
                        m_frames = 0;
                        slot = -1;
                        for (int i = 3; i >= 0; i--) if (!m_v[i]) slot = i;
                        if (slot >= 0) begin
                            nv[slot] = 1;
                            nh[slot] = int'(rand_hpos);
                            ny[slot] = VB;
                            m_sp = 1;
                        end else begin
                            m_ov = 1;
                        end
                    end
                end
                if (pause) m_mode = 2;
            end else begin
                if (pause) m_mode = 1;
            end
            for (int i = 0; i < 4; i++) if (clear_slot[i]) nv[i] = 0;
        end
        for (int i = 0; i < 4; i++) begin
            m_v[i] = nv[i];
            m_h[i] = nh[i];
            m_y[i] = ny[i];
        end
    endtask

    task automatic compare_all();
        logic [3:0]  ev;
        logic [39:0] eh, ey;
        for (int i = 0; i < 4; i++) begin
            ev[i] = m_v[i];
            eh[10*i +: 10] = 10'(m_h[i]);
            ey[10*i +: 10] = 10'(m_y[i]);
        end
        check("obj_valid", 64'(obj_valid), 64'(ev));
        check("obj_hpos", 64'(obj_hpos), 64'(eh));
        check("obj_vpos", 64'(obj_vpos), 64'(ey));
        check("spawned", 64'(spawned), 64'(m_sp));
        check("missed", 64'(missed), 64'(m_ms));
        check("overflow", 64'(overflow), 64'(m_ov));
    endtask

    task automatic step(input bit r, input bit s, input bit p, input bit t, input logic [3:0] c);
        rst = r; start = s; pause = p; frame_tick = t; clear_slot = c;
        rand_hpos = use_fixed ? fixed_h : 10'(lane());
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    logic [39:0] snap;
    logic [3:0]  cmask;
    int          spawn_seen;

    initial begin
        step(1, 0, 0, 0, 4'h0);
        step(1, 0, 0, 0, 4'h0);
        check("reset_valid", 64'(obj_valid), 64'h0);
        check("reset_vpos", 64'(obj_vpos), 64'h0);

        use_fixed = 1'b1;
        step(0, 1, 0, 0, 4'h0);
        for (int n = 1; n <= 60; n++) begin
            step(0, 0, 0, 1, 4'h0);
            if (n == 60) begin
                check("first_spawn", 64'(spawned), 64'h1);
                check("first_valid", 64'(obj_valid), 64'h1);
                check("first_hpos", 64'(obj_hpos[9:0]), 64'd415);
                check("first_vpos", 64'(obj_vpos[9:0]), 64'd31);
            end
            step(0, 0, 0, 0, 4'h0);
        end

        use_fixed = 1'b0;
        for (int n = 61; n <= 300; n++) begin
            step(0, 0, 0, 1, (n == 300) ? 4'b0010 : 4'b0000);
            if (n == 61) check("fall_step", 64'(obj_vpos[9:0]), 64'd33);
            if (n == 240) check("all_full", 64'(obj_valid), 64'hf);
            if (n == 300) begin
                check("ovf_pulse", 64'(overflow), 64'h1);
                check("ovf_missed", 64'(missed), 64'h1);
                check("ovf_valid", 64'(obj_valid), 64'b1100);
                check("retire_vpos", 64'(obj_vpos[9:0]), 64'd509);
            end
            step(0, 0, 0, 0, 4'h0);
        end
        for (int n = 0; n < 10; n++) begin
            step(0, 0, 0, 1, 4'h0);
            check("slot1_stays_free", 64'(obj_valid[1]), 64'h0);
        end

        step(0, 0, 1, 0, 4'h0);
        snap = obj_vpos;
        for (int n = 0; n < 10; n++) begin
            step(0, 1, 0, 1, 4'h0);
            check("pause_freeze", 64'(obj_vpos), 64'(snap));
        end
        step(0, 0, 1, 0, 4'h0);
        step(0, 0, 0, 1, 4'h0);
        check("resume_move", 64'(obj_vpos[39:30]), 64'(snap[39:30]) + 64'd2);

        for (int n = 0; n < 800; n++) begin
            cmask = '0;
            if ($urandom_range(0, 19) == 0) begin
                for (int i = 0; i < 4; i++) cmask[i] = m_v[i] & 1'($urandom);
            end
            step(0, $urandom_range(0, 49) == 0, $urandom_range(0, 39) == 0,
                 $urandom_range(0, 1) == 1, cmask);
        end

        if (m_mode == 2) step(0, 0, 1, 0, 4'h0);
        step(1, 1, 1, 1, 4'hf);
        check("rst_mid_valid", 64'(obj_valid), 64'h0);
        check("rst_mid_hpos", 64'(obj_hpos), 64'h0);
        spawn_seen = 0;
        for (int n = 0; n < 70; n++) begin
            step(0, 0, 0, 1, 4'h0);
            spawn_seen += int'(spawned);
            step(0, 0, 0, 0, 4'h0);
        end
        check("idle_no_spawn", 64'(spawn_seen), 64'h0);
        step(0, 1, 0, 0, 4'h0);
        for (int n = 1; n <= 60; n++) begin
            step(0, 0, 0, 1, 4'h0);
            if (n == 60) check("restart_spawn", 64'(spawned), 64'h1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
